pwm_multi: RTL and testbench
============================

Name: pwm_multi

Overview:
- Parametrised multi-channel PWM generator; successor to the single-channel fixed 8-bit PWM.
- One shared period counter, driven by a programmable clock prescaler, feeds CHANNELS compare units.
- Each channel has its own duty and output polarity.
- Config is taken through a valid/ready handshake into shadow registers and applied only at a period boundary, so outputs never glitch.
- Sits between the register/control logic and the motor/LED driver pins.

Parameters:
- CHANNELS, 4, number of independent PWM outputs (1..16)
- WIDTH, 8, counter/period/duty width in bits (4..16)
- PRESC_WIDTH, 8, prescaler register width

Ports:
- clk  in  1  system clock
- rst_n  in  1  asynchronous active-low reset
- enable  in  1  run enable; low = counter held, outputs inactive
- cfg_valid  in  1  new config offered this cycle
- cfg_ready  out  1  block can accept config
- period  in  WIDTH  terminal count; period length = period+1 ticks
- prescale  in  PRESC_WIDTH  tick every prescale+1 clk cycles
- duty  in  CHANNELS*WIDTH  per-channel compare value; channel i at [i*WIDTH +: WIDTH]
- polarity  in  CHANNELS  1 = invert that channel's output
- pwm_out  out  CHANNELS  registered PWM outputs
- period_start  out  1  one-clk pulse when the counter enters 0
- count  out  WIDTH  current counter value, for debug/sync

Behaviour:
- Reset (async, rst_n=0):
  - Counter 0, prescaler 0.
  - Active period = 2^WIDTH-1, active duty all 0, active polarity all 0.
  - Pending slot empty, cfg_ready=1, pwm_out=0, period_start=0.
- Prescaler:
  - presc_cnt counts 0..prescale_act; tick asserts in the cycle presc_cnt==prescale_act, then presc_cnt returns to 0.
  - prescale_act=0 gives a tick every clk.
- Counter (edge-aligned), on tick: 0 if count==period_act, else count+1.
  - period_act=0: count stays 0 and period_start pulses every tick.
- Boundary: the tick on which count wraps to 0. period_start is registered and high for the single clk following that tick.
- Compare, per channel i:
  - raw_i = (count < duty_act_i); pwm_out_i <= raw_i ^ polarity_act_i, registered.
  - Latency: 1 clk from count change to pwm_out.
  - duty=0 gives a constant inactive level.
  - duty > period_act gives a constant active level (100%).
  - Compare is unsigned at full WIDTH with no truncation.
- Handshake:
  - A transfer happens when cfg_valid && cfg_ready. period, prescale, duty and polarity are captured into the pending slot together.
  - cfg_ready drops the next cycle and stays low while the slot is full.
  - With enable=1, the pending slot moves to the active registers at the next boundary; cfg_ready rises the cycle after.
  - With enable=0, pending moves to active the cycle after capture.
  - A transfer in the same cycle as a boundary is applied at the following boundary, never the current one.
  - cfg_valid while cfg_ready=0 is ignored; the source must hold cfg_valid.
- Enable:
  - enable=0: count=0, presc_cnt=0, pwm_out=polarity_act (inactive level), period_start=0.
  - Rising enable: counting starts from 0, and period_start pulses on the first tick.
  - Falling enable mid-period: outputs go inactive the next clk.
- Reset asserted mid-operation discards the pending slot and returns to the reset values.

Optional Feature:
- Macro PWM_CENTER_EN.
- Defined:
  - Adds input center_mode (1 bit, sampled at apply time, held in the active config).
  - With center_mode=1, count runs up 0..period_act then down to 0, giving a period of 2*period_act ticks.
  - Compare and polarity are unchanged, so outputs are symmetric about the peak.
  - The boundary is the tick where a down-count reaches 0.
  - period_act=0 behaves as in edge mode.
- Undefined: port absent, edge-aligned only, no direction register.

Decomposition:
- Shared package pwm_pkg holds:
  - Default parameter values (PWM_DEF_WIDTH=8, PWM_DEF_CHANNELS=4).
  - The reset period constant (all-ones).
  - Direction encoding DIR_UP=0 / DIR_DOWN=1.
- One sub-module, pwm_prescaler: prescale input, tick output, clear on !enable.
- The compare units are a generate loop, not a separate module.

Test Plan:
- Reset, then enable=1 with defaults (period 255, prescale 0, duty 0) -> pwm_out=0 throughout, period_start every 256 clk, count wraps 255->0.
- Config period=9, prescale=0, duty ch0=3 / ch1=0 / ch2=10 / ch3=5, polarity=4'b1000 -> ch0 high 3 of 10 clk, ch1 always 0, ch2 always 1, ch3 low 5 then high 5.
- prescale=3, period=4, duty ch0=2 -> tick every 4 clk, period 20 clk, ch0 high 8 clk.
- Mid-period update of duty ch0 3->7 at count=5 -> current period keeps duty 3, next period shows 7; cfg_ready low from handshake until 1 clk after the boundary; a second cfg_valid in that window is not taken.
- Deassert rst_n at count=6 with the pending slot full -> all outputs 0, cfg_ready=1 immediately. After release, period=255 and duty=0.
- PWM_CENTER_EN, center_mode=1, period=4, duty ch0=2 -> count 0,1,2,3,4,3,2,1,0; ch0 high at counts 0,1 on both slopes; period_start every 8 clk.

Source files
------------

// File: rtl/pwm_pkg.sv
// pwm_pkg: shared defaults, reset constants and count-direction encoding for pwm_multi.
package pwm_pkg;

    localparam int PWM_DEF_WIDTH       = 8;
    localparam int PWM_DEF_CHANNELS    = 4;
    localparam int PWM_DEF_PRESC_WIDTH = 8;

    // Reset period is all-ones; sliced down to the instance WIDTH (max 16).
    localparam logic [15:0] PWM_RESET_PERIOD = 16'hFFFF;

    typedef enum logic {
        DIR_UP   = 1'b0,
        DIR_DOWN = 1'b1
    } dir_e;

endpackage

// File: rtl/pwm_prescaler.sv
// pwm_prescaler: emits a one-clk tick every prescale+1 enabled clock cycles; held clear while disabled.
module pwm_prescaler
    import pwm_pkg::*;
#(
    parameter int PRESC_WIDTH = PWM_DEF_PRESC_WIDTH
) (
    input  logic                   clk,
    input  logic                   rst_n,
    input  logic                   enable,
    input  logic [PRESC_WIDTH-1:0] prescale,
    output logic                   tick
);

    logic [PRESC_WIDTH-1:0] presc_cnt;

    assign tick = enable && (presc_cnt >= prescale);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            presc_cnt <= '0;
        end else if (!enable || tick) begin
            presc_cnt <= '0;
        end else begin
            presc_cnt <= presc_cnt + 1'b1;
        end
    end

endmodule

// File: rtl/pwm_multi.sv
// pwm_multi: shared-counter multi-channel PWM with shadowed config applied only at period boundaries.
// Defining PWM_CENTER_EN adds the center_mode input and up/down (center-aligned) counting.
module pwm_multi
    import pwm_pkg::*;
#(
    parameter int CHANNELS    = PWM_DEF_CHANNELS,
    parameter int WIDTH       = PWM_DEF_WIDTH,
    parameter int PRESC_WIDTH = PWM_DEF_PRESC_WIDTH
) (
    input  logic                      clk,
    input  logic                      rst_n,
    input  logic                      enable,
    input  logic                      cfg_valid,
    output logic                      cfg_ready,
    input  logic [WIDTH-1:0]          period,
    input  logic [PRESC_WIDTH-1:0]    prescale,
    input  logic [CHANNELS*WIDTH-1:0] duty,
    input  logic [CHANNELS-1:0]       polarity,
`ifdef PWM_CENTER_EN
    input  logic                      center_mode,
`endif
    output logic [CHANNELS-1:0]       pwm_out,
    output logic                      period_start,
    output logic [WIDTH-1:0]          count
);

    logic [WIDTH-1:0]          period_pend, period_act;
    logic [PRESC_WIDTH-1:0]    prescale_pend, prescale_act;
    logic [CHANNELS*WIDTH-1:0] duty_pend, duty_act;
    logic [CHANNELS-1:0]       polarity_pend, polarity_act;
    logic                      pend_full;
    logic                      start_wait;
    logic                      tick;
    logic                      wrap;
    logic                      take;
    logic                      apply;
    logic [WIDTH-1:0]          count_nxt;
    logic [WIDTH-1:0]          count_dec;
    logic [CHANNELS-1:0]       raw;
`ifdef PWM_CENTER_EN
    logic                      center_pend, center_act;
    dir_e                      dir, dir_nxt;
`endif

    assign take      = cfg_valid && !pend_full;
    assign apply     = pend_full && (!enable || wrap);
    assign cfg_ready = !pend_full;
    assign count_dec = count - 1'b1;

    pwm_prescaler #(
        .PRESC_WIDTH(PRESC_WIDTH)
    ) u_prescaler (
        .clk     (clk),
        .rst_n   (rst_n),
        .enable  (enable),
        .prescale(prescale_act),
        .tick    (tick)
    );

    // The first tick after enable is treated as a boundary so period_start marks the start of counting.
    always_comb begin
        count_nxt = count;
        wrap      = 1'b0;
`ifdef PWM_CENTER_EN
        dir_nxt   = dir;
`endif
        if (tick) begin
            if (start_wait) begin
                count_nxt = '0;
                wrap      = 1'b1;
`ifdef PWM_CENTER_EN
                dir_nxt   = DIR_UP;
`endif
            end
`ifdef PWM_CENTER_EN
            else if (center_act && (period_act != '0)) begin
                if (dir == DIR_UP) begin
                    if (count >= period_act) begin
                        count_nxt = count_dec;
                        if (count_dec == '0) begin
                            wrap = 1'b1;
                        end else begin
                            dir_nxt = DIR_DOWN;
                        end
                    end else begin
                        count_nxt = count + 1'b1;
                    end
                end else if (count <= WIDTH'(1)) begin
                    count_nxt = '0;
                    wrap      = 1'b1;
                    dir_nxt   = DIR_UP;
                end else begin
                    count_nxt = count_dec;
                end
            end
`endif
            else if (count >= period_act) begin
                count_nxt = '0;
                wrap      = 1'b1;
            end else begin
                count_nxt = count + 1'b1;
            end
        end
    end

    // Capture and apply are exclusive: capture needs an empty slot, apply needs a full one.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            pend_full     <= 1'b0;
            period_pend   <= '0;
            prescale_pend <= '0;
            duty_pend     <= '0;
            polarity_pend <= '0;
            period_act    <= PWM_RESET_PERIOD[WIDTH-1:0];
            prescale_act  <= '0;
            duty_act      <= '0;
            polarity_act  <= '0;
`ifdef PWM_CENTER_EN
            center_pend   <= 1'b0;
            center_act    <= 1'b0;
`endif
        end else if (take) begin
            pend_full     <= 1'b1;
            period_pend   <= period;
            prescale_pend <= prescale;
            duty_pend     <= duty;
            polarity_pend <= polarity;
`ifdef PWM_CENTER_EN
            center_pend   <= center_mode;
`endif
        end else if (apply) begin
            pend_full     <= 1'b0;
            period_act    <= period_pend;
            prescale_act  <= prescale_pend;
            duty_act      <= duty_pend;
            polarity_act  <= polarity_pend;
`ifdef PWM_CENTER_EN
            center_act    <= center_pend;
`endif
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            count        <= '0;
            start_wait   <= 1'b1;
            period_start <= 1'b0;
`ifdef PWM_CENTER_EN
            dir          <= DIR_UP;
`endif
        end else if (!enable) begin
            count        <= '0;
            start_wait   <= 1'b1;
            period_start <= 1'b0;
`ifdef PWM_CENTER_EN
            dir          <= DIR_UP;
`endif
        end else begin
            count        <= count_nxt;
            period_start <= wrap;
            if (tick) begin
                start_wait <= 1'b0;
            end
`ifdef PWM_CENTER_EN
            dir          <= dir_nxt;
`endif
        end
    end

    for (genvar i = 0; i < CHANNELS; i++) begin : g_cmp
        assign raw[i] = count < duty_act[i*WIDTH +: WIDTH];
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            pwm_out <= '0;
        end else if (!enable) begin
            pwm_out <= polarity_act;
        end else begin
            pwm_out <= raw ^ polarity_act;
        end
    end

endmodule

// File: tb/tb_pwm_multi.sv
// tb_pwm_multi: scoreboard bench for pwm_multi; a phase-based reference model predicts every clock's outputs.
module tb_pwm_multi;

    localparam int CHANNELS    = 4;
    localparam int WIDTH       = 8;
    localparam int PRESC_WIDTH = 8;

    logic                      clk       = 1'b0;
    logic                      rst_n     = 1'b0;
    logic                      enable    = 1'b0;
    logic                      cfg_valid = 1'b0;
    logic                      cfg_ready;
    logic [WIDTH-1:0]          period    = '0;
    logic [PRESC_WIDTH-1:0]    prescale  = '0;
    logic [CHANNELS*WIDTH-1:0] duty      = '0;
    logic [CHANNELS-1:0]       polarity  = '0;
`ifdef PWM_CENTER_EN
    logic                      center_mode = 1'b0;
`endif
    logic [CHANNELS-1:0]       pwm_out;
    logic                      period_start;
    logic [WIDTH-1:0]          count;

    int checks   = 0;
    int failures = 0;

    typedef struct {
        logic [CHANNELS-1:0] pwm;
        logic                ps;
        logic [WIDTH-1:0]    cnt;
        logic                rdy;
    } exp_t;

    exp_t sb[$];

    pwm_multi #(
        .CHANNELS   (CHANNELS),
        .WIDTH      (WIDTH),
        .PRESC_WIDTH(PRESC_WIDTH)
    ) dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .enable      (enable),
        .cfg_valid   (cfg_valid),
        .cfg_ready   (cfg_ready),
        .period      (period),
        .prescale    (prescale),
        .duty        (duty),
        .polarity    (polarity),
`ifdef PWM_CENTER_EN
        .center_mode (center_mode),
`endif
        .pwm_out     (pwm_out),
        .period_start(period_start),
        .count       (count)
    );

    always #5 clk = ~clk;

    task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] req);
        checks++;
        if (act !== req) begin
            failures++;
            $display("[TB] FAIL %s: got %0h, expected %0h at %0t", name, act, req, $time);
        end
    endtask

    // Reference model: tracks position within the period (tick index) and derives count from it.
    int unsigned         m_per, m_pre, m_cen;
    int unsigned         m_duty[CHANNELS];
    logic [CHANNELS-1:0] m_pol;
    int unsigned         p_per, p_pre, p_cen;
    int unsigned         p_duty[CHANNELS];
    logic [CHANNELS-1:0] p_pol;
    bit                  m_full;
    int unsigned         m_div, m_pos, m_count;
    bit                  m_fresh;
    logic [CHANNELS-1:0] m_out;
    bit                  m_ps;

    task automatic modelReset();
        m_per   = (1 << WIDTH) - 1;
        m_pre   = 0;
        m_cen   = 0;
        m_pol   = '0;
        m_full  = 1'b0;
        m_div   = 0;
        m_pos   = 0;
        m_count = 0;
        m_fresh = 1'b1;
        m_out   = '0;
        m_ps    = 1'b0;
        for (int i = 0; i < CHANNELS; i++) m_duty[i] = 0;
    endtask

    always @(posedge clk) begin : ref_model
        exp_t                e;
        logic [CHANNELS-1:0] nout;
        bit                  mtick, bnd;
        int unsigned         len;
        if (!rst_n) begin
            modelReset();
        end else begin
            len = (m_cen != 0 && m_per > 0) ? 2 * m_per : m_per + 1;
            for (int i = 0; i < CHANNELS; i++)
                nout[i] = enable ? ((m_count < m_duty[i]) ^ m_pol[i]) : m_pol[i];
            mtick = enable && (m_div == m_pre);
            bnd   = mtick && (m_fresh || m_pos == len - 1);
            if (!enable) begin
                m_div = 0; m_pos = 0; m_fresh = 1'b1;
            end else if (mtick) begin
                m_div = 0; m_pos = bnd ? 0 : m_pos + 1; m_fresh = 1'b0;
            end else begin
                m_div++;
            end
            if (cfg_valid && !m_full) begin
                p_per = period; p_pre = prescale; p_pol = polarity; p_cen = 0;
`ifdef PWM_CENTER_EN
                p_cen = center_mode;
`endif
                for (int i = 0; i < CHANNELS; i++) p_duty[i] = duty[i*WIDTH +: WIDTH];
                m_full = 1'b1;
            end else if (m_full && (!enable || bnd)) begin
                m_per = p_per; m_pre = p_pre; m_pol = p_pol; m_cen = p_cen;
                for (int i = 0; i < CHANNELS; i++) m_duty[i] = p_duty[i];
                m_full = 1'b0;
            end
            if (m_cen != 0 && m_per > 0 && m_pos > m_per) m_count = 2 * m_per - m_pos;
            else m_count = m_pos;
            m_out = nout;
            m_ps  = bnd;
        end
        e.pwm = m_out;
        e.ps  = m_ps;
        e.cnt = WIDTH'(m_count);
        e.rdy = !m_full;
        sb.push_back(e);
    end

    always @(negedge clk) begin : monitor
        exp_t e;
        if (sb.size() > 0) begin
            e = sb.pop_front();
            checkOutput("pwm_out", 32'(pwm_out), 32'(e.pwm));
            checkOutput("period_start", 32'(period_start), 32'(e.ps));
            checkOutput("count", 32'(count), 32'(e.cnt));
            checkOutput("cfg_ready", 32'(cfg_ready), 32'(e.rdy));
        end
    end

    task automatic applyStimulus(input int unsigned per, input int unsigned pre,
                                 input logic [CHANNELS*WIDTH-1:0] dv,
                                 input logic [CHANNELS-1:0] pol, input bit cm);
        bit done = 1'b0;
        @(posedge clk); #1;
        period    = WIDTH'(per);
        prescale  = PRESC_WIDTH'(pre);
        duty      = dv;
        polarity  = pol;
`ifdef PWM_CENTER_EN
        center_mode = cm;
`endif
        cfg_valid = 1'b1;
        for (int n = 0; n < 1000 && !done; n++) begin
            @(negedge clk);
            done = cfg_ready;
            @(posedge clk); #1;
        end
        cfg_valid = 1'b0;
        checkOutput("cfg_accepted", 32'(done), 32'd1);
        if (cm && 0) $display("[TB] unreachable");
    endtask

    task automatic waitApplied();
        bit seen = 1'b0;
        for (int n = 0; n < 2000 && !seen; n++) begin
            @(negedge clk);
            seen = cfg_ready;
        end
        checkOutput("cfg_applied", 32'(seen), 32'd1);
    endtask

    task automatic waitCount(input int v);
        bit seen = 1'b0;
        for (int n = 0; n < 2000 && !seen; n++) begin
            @(negedge clk);
            seen = (count == WIDTH'(v));
        end
        checkOutput("wait_count", 32'(seen), 32'd1);
    endtask

    task automatic sampleHigh(input int ncyc, input int sel, output int n);
        n = 0;
        repeat (ncyc) begin
            @(negedge clk);
            if (sel < 0) n += int'(period_start);
            else n += int'(pwm_out[sel]);
        end
    endtask

    initial begin : watchdog
        #2000000;
        $display("[TB] FAIL watchdog: simulation time limit reached");
        $fatal(1, "[TB] timeout");
    end

    initial begin : stimulus
        int n;
        repeat (3) @(posedge clk);
        #1 rst_n = 1'b1;

        // Defaults: period 255, duty 0.
        @(posedge clk); #1 enable = 1'b1;
        sampleHigh(520, -1, n);
        checkOutput("default_period_starts", 32'(n), 32'd3);

        applyStimulus(9, 0, {8'd5, 8'd10, 8'd0, 8'd3}, 4'b1000, 1'b0);
        waitApplied();
        repeat (3) @(negedge clk);
        sampleHigh(10, 0, n); checkOutput("ch0_high_of_10", 32'(n), 32'd3);
        sampleHigh(10, 1, n); checkOutput("ch1_high_of_10", 32'(n), 32'd0);
        sampleHigh(10, 2, n); checkOutput("ch2_high_of_10", 32'(n), 32'd10);
        sampleHigh(10, 3, n); checkOutput("ch3_high_of_10", 32'(n), 32'd5);

        applyStimulus(4, 3, {8'd5, 8'd10, 8'd0, 8'd2}, 4'b0000, 1'b0);
        waitApplied();
        repeat (3) @(negedge clk);
        sampleHigh(20, 0, n);  checkOutput("presc_ch0_high_of_20", 32'(n), 32'd8);
        sampleHigh(20, -1, n); checkOutput("presc_starts_of_20", 32'(n), 32'd1);

        // Mid-period duty update, then an offer while the slot is full that must be ignored.
        applyStimulus(9, 0, {8'd5, 8'd10, 8'd0, 8'd3}, 4'b1000, 1'b0);
        waitApplied();
        waitCount(5);
        applyStimulus(9, 0, {8'd5, 8'd10, 8'd0, 8'd7}, 4'b1000, 1'b0);
        duty[7:0] = 8'd9;
        cfg_valid = 1'b1;
        repeat (2) @(posedge clk);
        #1 cfg_valid = 1'b0;
        waitApplied();
        repeat (3) @(negedge clk);
        sampleHigh(10, 0, n); checkOutput("updated_ch0_high_of_10", 32'(n), 32'd7);

        // Reset with the pending slot full.
        waitCount(1);
        applyStimulus(9, 0, {8'd5, 8'd10, 8'd0, 8'd4}, 4'b1000, 1'b0);
        waitCount(5);
        @(posedge clk); #1;
        rst_n = 1'b0;
        sb.delete();
        #1;
        checkOutput("rst_pwm_out", 32'(pwm_out), 32'd0);
        checkOutput("rst_period_start", 32'(period_start), 32'd0);
        checkOutput("rst_cfg_ready", 32'(cfg_ready), 32'd1);
        checkOutput("rst_count", 32'(count), 32'd0);
        repeat (2) @(posedge clk);
        #1 rst_n = 1'b1;
        sampleHigh(300, 3, n); checkOutput("post_reset_ch3_high", 32'(n), 32'd0);

        // Randomized phase: config offers, enable toggles, data changing while valid is held.
        for (int c = 0; c < 2500; c++) begin
            @(posedge clk); #1;
            if ($urandom_range(0, 59) == 0) enable = ~enable;
            cfg_valid = ($urandom_range(0, 9) == 0);
            period    = WIDTH'($urandom_range(0, 12));
            prescale  = PRESC_WIDTH'($urandom_range(0, 3));
            polarity  = CHANNELS'($urandom);
            for (int i = 0; i < CHANNELS; i++) duty[i*WIDTH +: WIDTH] = WIDTH'($urandom_range(0, 14));
`ifdef PWM_CENTER_EN
            center_mode = $urandom_range(0, 1) == 1;
`endif
        end
        @(posedge clk); #1;
        cfg_valid = 1'b0;
        enable    = 1'b1;

`ifdef PWM_CENTER_EN
        applyStimulus(4, 0, {8'd5, 8'd10, 8'd0, 8'd2}, 4'b0000, 1'b1);
        waitApplied();
        repeat (3) @(negedge clk);
        sampleHigh(16, -1, n); checkOutput("center_starts_of_16", 32'(n), 32'd2);
        sampleHigh(8, 0, n);   checkOutput("center_ch0_high_of_8", 32'(n), 32'd3);
`endif

        repeat (20) @(posedge clk);
        @(negedge clk);
        $display("End of test - %0d assertions evaluated, %0d failures", checks, failures);
        $finish;
    end

endmodule
